p_inside: RTL and testbench

//  Downstream neighbour of the hit-point stage. Pops one hit point P (Q16.16) plus its

---
 rtl/ray_pkg.sv | 32 +++
 rtl/p_inside_edge_side.sv | 52 +++++
 rtl/p_inside.sv | 179 +++++++++++++++++
 tb/tb_p_inside.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared definitions for the ray/triangle pipeline stages.
//   fix_t             : signed Q16.16 scalar
//   vec3_t            : 3-component vector [x,y,z] of fix_t
//   Q_BITS_DEF        : default number of fractional bits
//   p_inside_state_t  : FSM states of the p_inside stage
//   sat32()           : clamp a wide signed value into signed 32 bits
package ray_pkg;

    typedef logic signed [31:0] fix_t;
    typedef fix_t vec3_t [2:0];

    localparam int Q_BITS_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_E1,
        ST_E2,
        ST_PUSH
    } p_inside_state_t;

    function automatic fix_t sat32(input logic signed [66:0] x);
        if (x > 67'sd2147483647) begin
            return 32'sh7fff_ffff;
        end else if (x < -67'sd2147483648) begin
            return 32'sh8000_0000;
        end else begin
            return fix_t'(x[31:0]);
        end
    endfunction

endpackage

// File: rtl/p_inside_edge_side.sv
// edge_side: combinational sign of ((b-a) x (p-a)) . n for one triangle edge.
// Ports:
//   a, b    in  vec3_t  edge endpoints (Q16.16)
//   p       in  vec3_t  hit point (Q16.16)
//   n       in  vec3_t  triangle normal (Q16.16)
//   nonneg  out 1       1 when the side value is >= 0 (point is on the inner side or on the edge)
module edge_side
    import ray_pkg::*;
#(
    parameter int Q_BITS = Q_BITS_DEF
) (
    input  vec3_t a,
    input  vec3_t b,
    input  vec3_t p,
    input  vec3_t n,
    output logic  nonneg
);

    logic signed [32:0] e [3];      // b - a, 33-bit so it never wraps
    logic signed [32:0] w [3];      // p - a
    logic signed [65:0] prod_a [3];
    logic signed [65:0] prod_b [3];
    logic signed [66:0] diff [3];   // one extra bit: difference of two 66-bit products
    logic signed [66:0] shifted [3];
    fix_t               c [3];      // cross product, back in Q16.16, saturated
    logic signed [63:0] dp [3];
    logic signed [65:0] dot;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_comp
            localparam int J = (gi + 1) % 3;
            localparam int K = (gi + 2) % 3;

            assign e[gi] = 33'(b[gi]) - 33'(a[gi]);
            assign w[gi] = 33'(p[gi]) - 33'(a[gi]);

            // c_i = e_j * w_k - e_k * w_j
            assign prod_a[gi]  = 66'(e[J]) * 66'(w[K]);
            assign prod_b[gi]  = 66'(e[K]) * 66'(w[J]);
            assign diff[gi]    = 67'(prod_a[gi]) - 67'(prod_b[gi]);
            assign shifted[gi] = diff[gi] >>> Q_BITS;
            assign c[gi]       = sat32(shifted[gi]);

            assign dp[gi] = 64'(c[gi]) * 64'(n[gi]);
        end
    endgenerate

    // Only the sign matters, so the dot product stays unscaled.
    assign dot    = 66'(dp[0]) + 66'(dp[1]) + 66'(dp[2]);
    assign nonneg = ~dot[65];

endmodule

// File: rtl/p_inside.sv
// p_inside: pops a hit point and its triangle from the upstream FIFO group, runs the
// three-edge inside test one edge per cycle, and queues {inside, P} in an output FIFO.
// Ports:
//   clock       in   1       rising-edge clock
//   reset       in   1       asynchronous active-low reset
//   p           in   vec3_t  hit point
//   v0, v1, v2  in   vec3_t  triangle vertices
//   normal      in   vec3_t  triangle normal
//   in_empty    in   1       upstream empty
//   in_rd_en    out  1       upstream pop; operands are latched in the same cycle
//   out         out  vec3_t  P of the head output entry (0 when empty)
//   out_inside  out  1       inside flag of the head entry (0 when empty)
//   out_rd_en   in   1       downstream pop (ignored when empty)
//   out_empty   out  1       output FIFO empty
// Build option: P_INSIDE_EARLY_EXIT_EN -- a negative side in E0/E1 skips straight to PUSH.
module p_inside
    import ray_pkg::*;
#(
    parameter int Q_BITS    = Q_BITS_DEF,
    parameter int OUT_DEPTH = 4
) (
    input  logic  clock,
    input  logic  reset,
    input  vec3_t p,
    input  vec3_t v0,
    input  vec3_t v1,
    input  vec3_t v2,
    input  vec3_t normal,
    input  logic  in_empty,
    output logic  in_rd_en,
    output vec3_t out,
    output logic  out_inside,
    input  logic  out_rd_en,
    output logic  out_empty
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    p_inside_state_t state_reg, state_next;

    vec3_t p_reg, v0_reg, v1_reg, v2_reg, n_reg;
    logic  all_nonneg_reg;

    vec3_t a_sel, b_sel;
    logic  side_nonneg;
    logic  push;
    logic  pop;
    logic  pending;
    logic [CNT_W:0] occupancy;

    vec3_t            mem_p [OUT_DEPTH];
    logic             mem_inside [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // A triangle in flight has already reserved an output slot.
    assign pending   = (state_reg != ST_IDLE);
    assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, pending};
    assign in_rd_en  = reset && (state_reg == ST_IDLE) && !in_empty
                       && (occupancy < (CNT_W + 1)'(OUT_DEPTH));

    // Single edge evaluator, operands steered by the current edge state.
    always_comb begin
        a_sel = v0_reg;
        b_sel = v1_reg;
        case (state_reg)
            ST_E1: begin
                a_sel = v1_reg;
                b_sel = v2_reg;
            end
            ST_E2: begin
                a_sel = v2_reg;
                b_sel = v0_reg;
            end
            default: ;
        endcase
    end

    edge_side #(.Q_BITS(Q_BITS)) u_edge_side (
        .a      (a_sel),
        .b      (b_sel),
        .p      (p_reg),
        .n      (n_reg),
        .nonneg (side_nonneg)
    );

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_rd_en) state_next = ST_E0;
            end
            ST_E0: begin
`ifdef P_INSIDE_EARLY_EXIT_EN
                state_next = side_nonneg ? ST_E1 : ST_PUSH;
`else
                state_next = ST_E1;
`endif
            end
            ST_E1: begin
`ifdef P_INSIDE_EARLY_EXIT_EN
                state_next = side_nonneg ? ST_E2 : ST_PUSH;
`else
                state_next = ST_E2;
`endif
            end
            ST_E2: begin
                state_next = ST_PUSH;
            end
            ST_PUSH: begin
                push       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            all_nonneg_reg <= 1'b0;
            p_reg          <= '{default: '0};
            v0_reg         <= '{default: '0};
            v1_reg         <= '{default: '0};
            v2_reg         <= '{default: '0};
            n_reg          <= '{default: '0};
        end else begin
            state_reg <= state_next;
            if (in_rd_en) begin
                p_reg          <= p;
                v0_reg         <= v0;
                v1_reg         <= v1;
                v2_reg         <= v2;
                n_reg          <= normal;
                all_nonneg_reg <= 1'b1;
            end else if (state_reg == ST_E0 || state_reg == ST_E1 || state_reg == ST_E2) begin
                all_nonneg_reg <= all_nonneg_reg & side_nonneg;
            end
        end
    end

    // Output FIFO. Push never overflows because the slot was reserved at pop time.
    assign out_empty = (count_reg == '0);
    assign pop       = out_rd_en && !out_empty;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_p[wr_ptr_reg]      <= p_reg;
            mem_inside[wr_ptr_reg] <= all_nonneg_reg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head entry shown combinationally; forced to zero when empty so reset shows zeros.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_out
            assign out[gi] = out_empty ? '0 : mem_p[rd_ptr_reg][gi];
        end
    endgenerate
    assign out_inside = out_empty ? 1'b0 : mem_inside[rd_ptr_reg];

endmodule

// File: tb/tb_p_inside.sv
module tb_p_inside;
    import ray_pkg::*;

    localparam fix_t ONE    = 32'sd65536;
    localparam fix_t HALF   = 32'sd32768;
    localparam fix_t QTR    = 32'sd16384;
    localparam fix_t EIGHTH = 32'sd8192;
    localparam fix_t BIG    = 32'sd1048576000;   // 16000.0
    localparam fix_t BIGX   = 32'sd1055129600;   // 16100.0

    logic  clock = 1'b0;
    logic  reset;
    vec3_t p, v0, v1, v2, normal, out;
    logic  in_empty, in_rd_en, out_inside, out_rd_en, out_empty;

    int n_pass  = 0;
    int n_total = 0;

    // upstream queue model
    vec3_t q_p [32], q_v0 [32], q_v1 [32], q_v2 [32], q_n [32];
    int    qh = 0, qt = 0;
    vec3_t t_v0, t_v1, t_v2, t_n;

    // values sampled each cycle
    logic        s_rd, s_empty, s_inside;
    logic [95:0] s_out;
    int          cyc = 0, s_cyc = 0, pops = 0;

    always #5 clock = ~clock;

    p_inside dut (
        .clock      (clock),
        .reset      (reset),
        .p          (p),
        .v0         (v0),
        .v1         (v1),
        .v2         (v2),
        .normal     (normal),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .out        (out),
        .out_inside (out_inside),
        .out_rd_en  (out_rd_en),
        .out_empty  (out_empty)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_tri(input fix_t ax, ay, az, bx, by, bz, cx, cy, cz, nx, ny, nz);
        t_v0 = '{az, ay, ax};
        t_v1 = '{bz, by, bx};
        t_v2 = '{cz, cy, cx};
        t_n  = '{nz, ny, nx};
    endtask

    task automatic enq(input fix_t px, py, pz);
        q_p[qt]  = '{pz, py, px};
        q_v0[qt] = t_v0;
        q_v1[qt] = t_v1;
        q_v2[qt] = t_v2;
        q_n[qt]  = t_n;
        qt++;
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, let the edge happen.
    task automatic tick();
        if (qh < qt) begin
            p        = q_p[qh];
            v0       = q_v0[qh];
            v1       = q_v1[qh];
            v2       = q_v2[qh];
            normal   = q_n[qh];
            in_empty = 1'b0;
        end else begin
            in_empty = 1'b1;
        end
        #1;
        s_rd     = in_rd_en;
        s_empty  = out_empty;
        s_inside = out_inside;
        s_out    = {out[2], out[1], out[0]};
        s_cyc    = cyc;
        @(posedge clock);
        if (s_rd) begin
            qh++;
            pops++;
        end
        cyc++;
        @(negedge clock);
    endtask

    // Wait for the next output entry, check it, then pop it.
    task automatic drain_one(input string tag, input fix_t px, py, pz, input logic exp_in);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (!s_empty) found = 1'b1;
        end
        chk({tag, ".seen"}, 96'(found), 96'(1));
        chk({tag, ".out"}, s_out, {pz, py, px});
        chk({tag, ".inside"}, 96'(s_inside), 96'(exp_in));
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;
    endtask

    // Single triangle into an empty pipeline: checks pop-to-visible latency and result.
    task automatic await_one(input string tag, input fix_t px, py, pz,
                             input logic exp_in, input int lat_ee);
        int exp_lat;
        int pop_cyc = -1;
        bit found   = 1'b0;
`ifdef P_INSIDE_EARLY_EXIT_EN
        exp_lat = lat_ee;
`else
        exp_lat = 5;
`endif
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (s_rd && pop_cyc < 0) pop_cyc = s_cyc;
            if (pop_cyc >= 0 && !s_empty) found = 1'b1;
        end
        chk({tag, ".seen"}, 96'(found), 96'(1));
        chk({tag, ".lat"}, 96'(s_cyc - pop_cyc), 96'(exp_lat));
        chk({tag, ".out"}, s_out, {pz, py, px});
        chk({tag, ".inside"}, 96'(s_inside), 96'(exp_in));
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;
        tick();
        chk({tag, ".empty_after"}, 96'(s_empty), 96'(1));
        $display("txn %s P=(%0d,%0d,%0d) inside=%0b lat=%0d", tag, px, py, pz, s_inside,
                 s_cyc - pop_cyc);
    endtask

    initial begin
        fix_t tx [6];
        fix_t ty [6];
        logic ti [6];
        int   pops0;
        bit   got;

        tx = '{QTR, ONE, HALF, QTR, 32'sd0, EIGHTH};
        ty = '{QTR, ONE, 32'sd0, -QTR, ONE, HALF};
        ti = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        reset     = 1'b0;
        in_empty  = 1'b0;        // upstream claims data during reset: pop must stay off
        out_rd_en = 1'b0;
        p         = '{default: '0};
        v0        = '{default: '0};
        v1        = '{default: '0};
        v2        = '{default: '0};
        normal    = '{default: '0};

        repeat (2) @(negedge clock);
        #1;
        chk("rst.out_empty", 96'(out_empty), 96'(1));
        chk("rst.in_rd_en", 96'(in_rd_en), 96'(0));
        chk("rst.out", {out[2], out[1], out[0]}, 96'(0));
        chk("rst.out_inside", 96'(out_inside), 96'(0));
        @(negedge clock);
        reset = 1'b1;

        // unit triangle in the z=0 plane
        set_tri(0, 0, 0, ONE, 0, 0, 0, ONE, 0, 0, 0, ONE);

        enq(QTR, QTR, 0);
        await_one("t1_inside", QTR, QTR, 0, 1'b1, 5);

        enq(ONE, ONE, 0);                        // fails on edge v1-v2
        await_one("t2_outside", ONE, ONE, 0, 1'b0, 4);

        enq(QTR, -QTR, 0);                       // fails on edge v0-v1
        await_one("t2b_outside_e0", QTR, -QTR, 0, 1'b0, 3);

        enq(HALF, 0, 0);                         // on edge v0-v1
        await_one("t3_on_edge", HALF, 0, 0, 1'b1, 5);

        enq(0, ONE, 0);                          // on vertex v2
        await_one("t3_vertex", 0, ONE, 0, 1'b1, 5);

        // back-pressure: 6 triangles, downstream stalled
        pops0 = pops;
        for (int i = 0; i < 6; i++) enq(tx[i], ty[i], 0);
        repeat (40) tick();
        chk("t4.pops_while_full", 96'(pops - pops0), 96'(4));
        chk("t4.in_rd_en_held", 96'(s_rd), 96'(0));
        chk("t4.not_empty", 96'(s_empty), 96'(0));
        for (int i = 0; i < 6; i++) begin
            drain_one($sformatf("t4_entry%0d", i), tx[i], ty[i], 0, ti[i]);
            $display("txn t4 entry %0d P=(%0d,%0d) inside=%0b", i, tx[i], ty[i], s_inside);
        end
        chk("t4.total_pops", 96'(pops - pops0), 96'(6));
        tick();
        chk("t4.empty_end", 96'(s_empty), 96'(1));

        // reset in E1 with two entries queued
        pops0 = pops;
        enq(QTR, QTR, 0);
        enq(HALF, 0, 0);
        repeat (15) tick();
        chk("t5.pops_before", 96'(pops - pops0), 96'(2));
        chk("t5.count2_nonempty", 96'(s_empty), 96'(0));
        enq(ONE, ONE, 0);                        // this one is discarded by reset
        enq(EIGHTH, HALF, 0);                    // processed after reset
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (s_rd) got = 1'b1;
        end
        chk("t5.third_popped", 96'(got), 96'(1));
        tick();                                  // E0; next cycle is E1
        reset = 1'b0;
        in_empty = 1'b0;
        #1;
        chk("t5.rst_out_empty", 96'(out_empty), 96'(1));
        chk("t5.rst_in_rd_en", 96'(in_rd_en), 96'(0));
        chk("t5.rst_out", {out[2], out[1], out[0]}, 96'(0));
        $display("txn t5 reset asserted in E1");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        await_one("t5_after_reset", EIGHTH, HALF, 0, 1'b1, 5);

        // large triangle: cross terms saturate
        set_tri(-BIG, -BIG, 0, BIG, -BIG, 0, 0, BIG, 0, 0, 0, ONE);
        enq(0, 0, 0);
        await_one("t6_big_inside", 0, 0, 0, 1'b1, 5);
        enq(0, -BIGX, 0);
        await_one("t6_big_below", 0, -BIGX, 0, 1'b0, 3);
        enq(BIG, BIG, 0);
        await_one("t6_big_right", BIG, BIG, 0, 1'b0, 4);
        set_tri(-BIG, -BIG, 0, BIG, -BIG, 0, 0, BIG, 0, 0, 0, -ONE);
        enq(0, 0, 0);
        await_one("t6_big_flipped_n", 0, 0, 0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
